// File: rtl/rambit_bist.sv
// March C- self-test controller and functional port mux for a bit-masked
// single-port RAM with registered, read-first read data.
module rambit_bist #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          usr_ce,
    input  logic [DW-1:0] usr_we,
    input  logic [AW-1:0] usr_addr,
    input  logic [DW-1:0] usr_din,
    output logic [DW-1:0] usr_dout,
    output logic          mem_ce,
    output logic [DW-1:0] mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_mask
);

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_FIN
    } state_t;

    localparam logic [AW-1:0] ADDR_MAX = '1;

    state_t        state, state_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic          rd_en;
    logic [DW-1:0] rd_exp;
    logic          vld_p0;
    logic [DW-1:0] exp_p0;
    logic [AW-1:0] addr_p0;
    logic          miscmp;

    // Data written by each element (only meaningful while mem_we is set).
    function automatic logic [DW-1:0] wr_pattern(input state_t s);
        logic [DW-1:0] p;
        case (s)
            S_M1, S_M3: p = '1;
            default:    p = '0;
        endcase
        return p;
    endfunction

    // Data each read element expects to find before it overwrites the word.
    function automatic logic [DW-1:0] rd_expect(input state_t s);
        logic [DW-1:0] p;
        case (s)
            S_M2, S_M4: p = '1;
            default:    p = '0;
        endcase
        return p;
    endfunction

    // State and sweep address register; reset only touches control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            addr_q <= '0;
        end else begin
            state  <= state_nxt;
            addr_q <= addr_nxt;
        end
    end

    // Element sequencing with explicit terminal-address detection per direction.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_M0;
                    addr_nxt  = '0;
                end
            end
            S_M0, S_M1, S_M2, S_M5: begin
                if (addr_q == ADDR_MAX) begin
                    case (state)
                        S_M0:    begin state_nxt = S_M1;    addr_nxt = '0;       end
                        S_M1:    begin state_nxt = S_M2;    addr_nxt = '0;       end
                        S_M2:    begin state_nxt = S_M3;    addr_nxt = ADDR_MAX; end
                        default: begin state_nxt = S_DRAIN; addr_nxt = '0;       end
                    endcase
                end else begin
                    addr_nxt = addr_q + 1'b1;
                end
            end
            S_M3, S_M4: begin
                if (addr_q == '0) begin
                    if (state == S_M3) begin
                        state_nxt = S_M4;
                        addr_nxt  = ADDR_MAX;
                    end else begin
                        state_nxt = S_M5;
                        addr_nxt  = '0;
                    end
                end else begin
                    addr_nxt = addr_q - 1'b1;
                end
            end
            S_DRAIN: state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // RAM port drive: controller owns the port while busy, otherwise pass-through.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        rd_en    = 1'b0;
        rd_exp   = rd_expect(state);
        mem_ce   = usr_ce;
        mem_we   = usr_we;
        mem_addr = usr_addr;
        mem_din  = usr_din;
        case (state)
            S_M0, S_M1, S_M2, S_M3, S_M4: begin
                busy     = 1'b1;
                rd_en    = (state != S_M0);
                mem_ce   = 1'b1;
                mem_we   = '1;
                mem_addr = addr_q;
                mem_din  = wr_pattern(state);
            end
            S_M5: begin
                busy     = 1'b1;
                rd_en    = 1'b1;
                mem_ce   = 1'b1;
                mem_we   = '0;
                mem_addr = addr_q;
                mem_din  = '0;
            end
            S_DRAIN: begin
                busy     = 1'b1;
                mem_ce   = 1'b0;
                mem_we   = '0;
                mem_addr = addr_q;
                mem_din  = '0;
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    assign usr_dout = mem_dout;

    // ---- stage p0: compare stage loaded on each read cycle, used when data returns
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_en;
        end
    end

    // Expected pattern and address travel alongside vld_p0 (data path, no reset).
    always_ff @(posedge clk) begin
        exp_p0  <= rd_exp;
        addr_p0 <= addr_q;
    end

    assign miscmp = vld_p0 && (mem_dout != exp_p0);

    // Sticky failure flag; only the first miscompare of a run is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_mask <= '0;
        end else if (state == S_IDLE && start) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_mask <= '0;
        end else if (miscmp && !fail) begin
            fail      <= 1'b1;
            fail_addr <= addr_p0;
            fail_mask <= mem_dout ^ exp_p0;
        end
    end

endmodule
